// File: rtl/ascon_aead128_pkg.sv
// Shared constants and FSM state type for the Ascon-AEAD128 rate-block buffer.
package ascon_aead128_pkg;
  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_RATE_WIDTH  = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam logic [7:0] PAD_BYTE = 8'h01;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    EXTRA = 2'd2
  } state_e;
endpackage

// File: rtl/ascon_pad.sv
// Combinational pad: keeps bytes below n, writes PAD_BYTE at n (if inside the block), zeroes the rest.
module ascon_pad
  import ascon_aead128_pkg::*;
#(
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) (
  input  logic [RATE_WIDTH-1:0] block,
  input  logic [4:0]            n,
  output logic [RATE_WIDTH-1:0] padded
);
  localparam int NBYTES = RATE_WIDTH / 8;

  always_comb begin
    padded = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < int'(n)) begin
        padded[8*i +: 8] = block[8*i +: 8];
      end else if (i == int'(n)) begin
        padded[8*i +: 8] = PAD_BYTE;
      end
    end
  end
endmodule

// File: rtl/ascon_block_buffer.sv
// Packs little-endian input words into padded Ascon-AEAD128 rate blocks.
// Optional 16-bit output-block counter port blk_cnt when ASCON_BLOCK_CNT_EN is defined.
module ascon_block_buffer
  import ascon_aead128_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_bytes,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RATE_WIDTH-1:0] out_block,
  output logic                  out_last,
  output logic [4:0]            out_bytes,
  output state_e                dbg_state
`ifdef ASCON_BLOCK_CNT_EN
  ,
  output logic [15:0]           blk_cnt
`endif
);
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int KW             = $clog2(WORDS_PER_BLOCK);

  // Both ports are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid holds its payload until that edge. Input is
  // only taken in FILL and output only offered outside FILL, so they never overlap.
  state_e                state;
  logic [KW-1:0]         k;
  logic [RATE_WIDTH-1:0] blk_q;
  logic                  pending_extra;

  logic [2:0]            last_bytes;
  logic [4:0]            n;
  logic [RATE_WIDTH-1:0] word_ext;
  logic [RATE_WIDTH-1:0] merged;
  logic [RATE_WIDTH-1:0] padded;
  logic                  in_hs;
  logic                  out_hs;

  assign in_ready  = (state == FILL);
  assign out_valid = (state != FILL);
  assign out_block = blk_q;
  assign dbg_state = state;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  assign last_bytes = (in_bytes > 3'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : in_bytes;
  assign n          = 5'(k) * 5'(BYTES_PER_WORD) + 5'(last_bytes);
  assign word_ext   = RATE_WIDTH'(in_data) << (WORD_WIDTH * int'(k));
  assign merged     = blk_q | word_ext;

  // Garbage bytes above in_bytes in the final word are removed by the pad stage.
  ascon_pad #(.RATE_WIDTH(RATE_WIDTH)) u_pad (
    .block  (merged),
    .n      (n),
    .padded (padded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      k             <= '0;
      blk_q         <= '0;
      pending_extra <= 1'b0;
      out_last      <= 1'b0;
      out_bytes     <= '0;
    end else if (clear) begin
      state         <= FILL;
      k             <= '0;
      blk_q         <= '0;
      pending_extra <= 1'b0;
      out_last      <= 1'b0;
      out_bytes     <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            if (in_last) begin
              blk_q     <= padded;
              out_bytes <= n;
              k         <= '0;
              state     <= FULL;
              // A message ending exactly on a block boundary needs a pad-only block.
              if (n == 5'(RATE_WIDTH / 8)) begin
                out_last      <= 1'b0;
                pending_extra <= 1'b1;
              end else begin
                out_last <= 1'b1;
              end
            end else if (k == KW'(WORDS_PER_BLOCK - 1)) begin
              blk_q     <= merged;
              out_bytes <= 5'(RATE_WIDTH / 8);
              out_last  <= 1'b0;
              k         <= '0;
              state     <= FULL;
            end else begin
              blk_q <= merged;
              k     <= k + KW'(1);
            end
          end
        end
        FULL: begin
          if (out_hs) begin
            if (pending_extra) begin
              blk_q     <= {{(RATE_WIDTH-1){1'b0}}, 1'b1};
              out_bytes <= '0;
              out_last  <= 1'b1;
              state     <= EXTRA;
            end else begin
              blk_q     <= '0;
              out_bytes <= '0;
              out_last  <= 1'b0;
              k         <= '0;
              state     <= FILL;
            end
          end
        end
        EXTRA: begin
          if (out_hs) begin
            pending_extra <= 1'b0;
            blk_q         <= '0;
            out_bytes     <= '0;
            out_last      <= 1'b0;
            k             <= '0;
            state         <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef ASCON_BLOCK_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (clear) begin
      blk_cnt <= '0;
    end else if (out_hs) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ascon_block_buffer.sv
// Bench for ascon_block_buffer: directed vectors plus random messages checked against a byte-level model.
module tb_ascon_block_buffer;
  import ascon_aead128_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         out_last;
  logic [4:0]   out_bytes;
  state_e       dbg_state;
`ifdef ASCON_BLOCK_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  ascon_block_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_last  (out_last),
    .out_bytes (out_bytes),
    .dbg_state (dbg_state)
`ifdef ASCON_BLOCK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [127:0] exp_q[$];
  logic [4:0]   exp_bytes_q[$];
  logic         exp_last_q[$];
  logic [127:0] got_q[$];
  logic [4:0]   got_bytes_q[$];
  logic         got_last_q[$];
  logic [7:0]   msg_q[$];

  task automatic clear_queues();
    exp_q.delete(); exp_bytes_q.delete(); exp_last_q.delete();
    got_q.delete(); got_bytes_q.delete(); got_last_q.delete();
    msg_q.delete();
  endtask

  // Reference model: a message of L bytes becomes floor(L/16) full blocks
  // followed by one final block holding the L%16 tail bytes and a 0x01 pad.
  task automatic model_msg();
    int len;
    int nfull;
    int r;
    logic [127:0] blk;
    len   = msg_q.size();
    nfull = len / 16;
    r     = len % 16;
    for (int c = 0; c < nfull; c++) begin
      blk = '0;
      for (int b = 0; b < 16; b++) blk[8*b +: 8] = msg_q[16*c + b];
      exp_q.push_back(blk); exp_bytes_q.push_back(5'd16); exp_last_q.push_back(1'b0);
    end
    blk = '0;
    for (int b = 0; b < r; b++) blk[8*b +: 8] = msg_q[16*nfull + b];
    blk[8*r +: 8] = 8'h01;
    exp_q.push_back(blk); exp_bytes_q.push_back(5'(r)); exp_last_q.push_back(1'b1);
  endtask

  // Drains presented blocks with random backpressure into the got queues.
  task automatic collect_outputs();
    int cyc;
    cyc = 0;
    while (out_valid === 1'b1 && cyc < 200) begin
      n_vectors++;
      if (in_ready !== 1'b0) begin
        n_miscompares++;
        $display("FAIL ready_overlap: in_ready=%b while out_valid=1, required 0", in_ready);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_ready) begin
        got_q.push_back(out_block); got_bytes_q.push_back(out_bytes); got_last_q.push_back(out_last);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      cyc++;
    end
    if (out_valid === 1'b1) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL drain_timeout: out_valid still 1 after %0d cycles, required 0", cyc);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb, input bit do_collect);
    int cyc;
    cyc = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
    while (in_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (in_ready !== 1'b1) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; in_data = $urandom;
    if (do_collect) collect_outputs();
  endtask

  task automatic test_reset();
    n_vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== FILL) begin
      n_miscompares++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b state=%0d, required 1 0 0", in_ready, out_valid, dbg_state);
    end
    n_vectors++;
    if (out_last !== 1'b0 || out_bytes !== 5'd0 || out_block !== 128'h0) begin
      n_miscompares++;
      $display("FAIL reset_out: last=%b bytes=%0d block=%h, required 0 0 0", out_last, out_bytes, out_block);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_two_words();
    clear_queues();
    send_word(32'h03020100, 1'b0, 3'd0, 1'b1);
    send_word(32'h07060504, 1'b1, 3'd4, 1'b1);
    n_vectors++;
    if (got_q.size() != 1) begin
      n_miscompares++;
      $display("FAIL two_words_count: got %0d blocks, required 1", got_q.size());
    end else if (got_q[0] !== 128'h01_0706050403020100 || got_bytes_q[0] !== 5'd8 || got_last_q[0] !== 1'b1) begin
      n_miscompares++;
      $display("FAIL two_words: block=%h bytes=%0d last=%b, required 010706050403020100 8 1", got_q[0], got_bytes_q[0], got_last_q[0]);
    end
  endtask

  task automatic test_full_block();
    clear_queues();
    send_word(32'h03020100, 1'b0, 3'd0, 1'b1);
    send_word(32'h07060504, 1'b0, 3'd0, 1'b1);
    send_word(32'h0B0A0908, 1'b0, 3'd0, 1'b1);
    send_word(32'h0F0E0D0C, 1'b1, 3'd4, 1'b1);
    n_vectors++;
    if (got_q.size() != 2) begin
      n_miscompares++;
      $display("FAIL full_count: got %0d blocks, required 2", got_q.size());
    end else begin
      n_vectors++;
      if (got_q[0] !== 128'h0F0E0D0C0B0A09080706050403020100 || got_bytes_q[0] !== 5'd16 || got_last_q[0] !== 1'b0) begin
        n_miscompares++;
        $display("FAIL full_first: block=%h bytes=%0d last=%b, required 0f0e..0100 16 0", got_q[0], got_bytes_q[0], got_last_q[0]);
      end
      if (got_q[1] !== 128'h1 || got_bytes_q[1] !== 5'd0 || got_last_q[1] !== 1'b1) begin
        n_miscompares++;
        $display("FAIL full_extra: block=%h bytes=%0d last=%b, required 1 0 1", got_q[1], got_bytes_q[1], got_last_q[1]);
      end
    end
  endtask

  task automatic test_empty();
    clear_queues();
    send_word($urandom, 1'b1, 3'd0, 1'b1);
    n_vectors++;
    if (got_q.size() != 1) begin
      n_miscompares++;
      $display("FAIL empty_count: got %0d blocks, required 1", got_q.size());
    end else if (got_q[0] !== 128'h1 || got_bytes_q[0] !== 5'd0 || got_last_q[0] !== 1'b1) begin
      n_miscompares++;
      $display("FAIL empty: block=%h bytes=%0d last=%b, required 1 0 1", got_q[0], got_bytes_q[0], got_last_q[0]);
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    send_word(32'h03020100, 1'b0, 3'd0, 1'b1);
    send_word(32'h000000AA, 1'b1, 3'd1, 1'b0);
    // Offer a stray word during the stall; it must not be absorbed.
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== 128'h01AA_03020100 ||
          out_bytes !== 5'd5 || out_last !== 1'b1) begin
        n_miscompares++;
        $display("FAIL stall_%0d: valid=%b ready=%b block=%h bytes=%0d last=%b, required 1 0 01aa03020100 5 1",
                 i, out_valid, in_ready, out_block, out_bytes, out_last);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    collect_outputs();
    n_vectors++;
    if (got_q.size() != 1) begin
      n_miscompares++;
      $display("FAIL stall_count: got %0d blocks, required 1", got_q.size());
    end
    clear_queues();
    send_word($urandom, 1'b1, 3'd0, 1'b1);
    n_vectors++;
    if (got_q.size() != 1 || got_q[0] !== 128'h1) begin
      n_miscompares++;
      $display("FAIL stall_residue: got %0d blocks first=%h, required 1 block of 1", got_q.size(), got_q.size() > 0 ? got_q[0] : 128'h0);
    end
  endtask

  task automatic test_flush(input bit use_rst);
    clear_queues();
    send_word($urandom, 1'b0, 3'd0, 1'b1);
    send_word($urandom, 1'b0, 3'd0, 1'b1);
    if (use_rst) rst_n = 1'b0;
    else clear = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; clear = 1'b0;
    n_vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_miscompares++;
      $display("FAIL flush_hs(rst=%0d): in_ready=%b out_valid=%b, required 1 0", use_rst, in_ready, out_valid);
    end
    send_word(32'h33221100, 1'b1, 3'd4, 1'b1);
    n_vectors++;
    if (got_q.size() != 1 || got_q[0] !== 128'h01_33221100 || got_bytes_q[0] !== 5'd4 || got_last_q[0] !== 1'b1) begin
      n_miscompares++;
      $display("FAIL flush_next(rst=%0d): count=%0d block=%h, required 1 block 0133221100 bytes 4 last 1",
               use_rst, got_q.size(), got_q.size() > 0 ? got_q[0] : 128'h0);
    end
    if (!use_rst) begin
      // Clear coinciding with an output handshake discards that handshake.
      send_word(32'h44332211, 1'b1, 3'd2, 1'b0);
      out_ready = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; clear = 1'b0;
      n_vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_miscompares++;
        $display("FAIL clear_hs: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int nw;
    logic [2:0] lb;
    logic [31:0] d;
    int keep;
    clear_queues();
    for (int m = 0; m < 40; m++) begin
      msg_q.delete();
      nw = $urandom_range(1, 9);
      lb = 3'($urandom_range(0, 7));
      for (int w = 0; w < nw; w++) begin
        d = $urandom;
        keep = (w == nw - 1) ? ((lb > 3'd4) ? 4 : int'(lb)) : 4;
        for (int b = 0; b < keep; b++) msg_q.push_back(d[8*b +: 8]);
        send_word(d, (w == nw - 1), lb, 1'b1);
      end
      model_msg();
    end
    n_vectors++;
    if (got_q.size() != exp_q.size()) begin
      n_miscompares++;
      $display("FAIL random_count: got %0d blocks, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vectors++;
        if (got_q[i] !== exp_q[i] || got_bytes_q[i] !== exp_bytes_q[i] || got_last_q[i] !== exp_last_q[i]) begin
          n_miscompares++;
          $display("FAIL random_blk_%0d: block=%h bytes=%0d last=%b, required %h %0d %b",
                   i, got_q[i], got_bytes_q[i], got_last_q[i], exp_q[i], exp_bytes_q[i], exp_last_q[i]);
        end
      end
    end
  endtask

`ifdef ASCON_BLOCK_CNT_EN
  task automatic test_blk_cnt();
    clear_queues();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b1, 3'd2, 1'b1);
    n_vectors++;
    if (blk_cnt !== 16'd3) begin
      n_miscompares++;
      $display("FAIL blk_cnt: got %0d, required 3", blk_cnt);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    n_vectors++;
    if (blk_cnt !== 16'd0) begin
      n_miscompares++;
      $display("FAIL blk_cnt_clear: got %0d, required 0", blk_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_two_words();
    test_full_block();
    test_empty();
    test_backpressure();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
`ifdef ASCON_BLOCK_CNT_EN
    test_blk_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
